// File: rtl/memory_arbiter.sv
// Shared single-port RAM arbiter between instruction fetch and data load/store.
// When both sides request, they alternate. The bus is released on completion, on abort or on timeout.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic        last_r;   // 1'b1 when the most recent grant went to the data side
  logic [7:0]  cnt_r;
  logic        err_r;
  logic        dreq_s;
  logic        iown_s;
  logic        down_s;
  logic        tmo_s;

  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_r;

  // RAM strobes, hits and timeout detect decoded from the owner and its live request
  always_comb begin
    dreq_s   = dREN | dWEN;
    iown_s   = (state_r == IACC) && iREN;
    down_s   = (state_r == DACC) && dreq_s;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    if (iown_s) begin
      ramREN  = 1'b1;
      ramaddr = iaddr;
    end else if (down_s) begin
      ramaddr = daddr;
      if (dWEN) begin
        ramWEN   = 1'b1;
        ramstore = dstore;
      end else begin
        ramREN = 1'b1;
      end
    end else begin
      ramREN = 1'b0;
    end
    ihit  = iown_s & ramready;
    dhit  = down_s & ramready;
    tmo_s = (iown_s | down_s) & ~ramready & (cnt_r == TMAX);
  end

  // Arbitration FSM, wait counter and sticky timeout flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      last_r  <= 1'b0;
      cnt_r   <= 8'h00;
      err_r   <= 1'b0;
    end else begin
      if (tmo_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
      case (state_r)
        IDLE: begin
          cnt_r <= 8'h00;
          if (dreq_s && iREN) begin
            if (last_r) begin
              state_r <= IACC;
              last_r  <= 1'b0;
            end else begin
              state_r <= DACC;
              last_r  <= 1'b1;
            end
          end else if (dreq_s) begin
            state_r <= DACC;
            last_r  <= 1'b1;
          end else if (iREN) begin
            state_r <= IACC;
            last_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        IACC, DACC: begin
          // An abort, a completion or a timeout each release the bus for one idle cycle.
          if (!(iown_s || down_s) || ramready || tmo_s) begin
            state_r <= IDLE;
            cnt_r   <= 8'h00;
          end else begin
            cnt_r <= cnt_r + 8'h01;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by randomized traffic.
// Expected values come from a transaction-level ownership model.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  // Model: owner (0 none, 1 instr, 2 data), cycle number within access, who was served last, error
  int m_own, m_cyc;
  bit m_lastd, m_err;
  int ih_cnt, dh_cnt;
  bit last_ih, last_dh;
  int seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cyc = 0; m_lastd = 1'b0; m_err = 1'b0;
  endtask

  // Compare one cycle at the falling edge, then advance the model across the rising edge
  task automatic tick();
    bit act, dreq, e_ren, e_wen, e_ih, e_dh;
    logic [31:0] e_addr, e_store;
    @(negedge CLK);
    dreq    = dREN | dWEN;
    act     = (m_own == 1 && iREN) || (m_own == 2 && dreq);
    e_ren   = act && (m_own == 1 || !dWEN);
    e_wen   = act && m_own == 2 && dWEN;
    e_addr  = !act ? 32'h0 : (m_own == 1 ? iaddr : daddr);
    e_store = e_wen ? dstore : 32'h0;
    e_ih    = act && m_own == 1 && ramready;
    e_dh    = act && m_own == 2 && ramready;
    check("ramREN", {31'h0, ramREN}, {31'h0, e_ren});
    check("ramWEN", {31'h0, ramWEN}, {31'h0, e_wen});
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("ihit", {31'h0, ihit}, {31'h0, e_ih});
    check("dhit", {31'h0, dhit}, {31'h0, e_dh});
    check("err", {31'h0, err}, {31'h0, m_err});
    check("hit_excl", {31'h0, ihit & dhit}, 32'h0);
    if (e_ih) check("iload", iload, ramload);
    if (e_dh && !dWEN) check("dload", dload, ramload);
    if (ihit) begin ih_cnt++; seq.push_back(1); end
    if (dhit) begin dh_cnt++; seq.push_back(2); end
    last_ih = e_ih;
    last_dh = e_dh;
    if (m_own != 0) begin
      if (act && !ramready && m_cyc == TO) m_err = 1'b1;
      if (!act || ramready || m_cyc == TO) begin
        m_own = 0; m_cyc = 0;
      end else begin
        m_cyc++;
      end
    end else if (iREN && dreq) begin
      m_own = m_lastd ? 1 : 2; m_lastd = !m_lastd; m_cyc = 1;
    end else if (dreq) begin
      m_own = 2; m_lastd = 1'b1; m_cyc = 1;
    end else if (iREN) begin
      m_own = 1; m_lastd = 1'b0; m_cyc = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ramREN"}, {31'h0, ramREN}, 32'h0);
    check({tag, "_ramWEN"}, {31'h0, ramWEN}, 32'h0);
    check({tag, "_ramaddr"}, ramaddr, 32'h0);
    check({tag, "_ramstore"}, ramstore, 32'h0);
    check({tag, "_ihit"}, {31'h0, ihit}, 32'h0);
    check({tag, "_dhit"}, {31'h0, dhit}, 32'h0);
    check({tag, "_err"}, {31'h0, err}, 32'h0);
  endtask

  initial begin
    int r;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
    ih_cnt = 0; dh_cnt = 0; last_ih = 1'b0; last_dh = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Instruction read completing in its third strobe cycle
    iREN = 1'b1; iaddr = 32'h40; tick();
    tick(); tick();
    ramready = 1'b1; ramload = 32'hDEAD_BEEF; tick();
    iREN = 1'b0; ramready = 1'b0; tick();
    check("t1_ihit_count", ih_cnt, 32'd1);

    // Both sides held: grants alternate D, I, D, I
    seq.delete();
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; ramready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ramload = $urandom; tick();
    end
    iREN = 1'b0; dREN = 1'b0; ramready = 1'b0; tick();
    check("t2_nhits", seq.size(), 32'd4);
    if (seq.size() == 4) begin
      check("t2_g0", seq[0], 32'd2); check("t2_g1", seq[1], 32'd1);
      check("t2_g2", seq[2], 32'd2); check("t2_g3", seq[3], 32'd1);
    end

    // Data write
    r = dh_cnt;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234_5678; tick();
    ramready = 1'b1; tick();
    dWEN = 1'b0; ramready = 1'b0; tick();
    check("t3_dhit_count", dh_cnt, r + 1);

    // Data read aborted in its second cycle; the waiting fetch is served next
    r = dh_cnt;
    dREN = 1'b1; daddr = 32'h300; tick();
    iREN = 1'b1; iaddr = 32'h44; tick();
    dREN = 1'b0; tick();
    tick();
    ramready = 1'b1; ramload = 32'hCAFE_0001; tick();
    iREN = 1'b0; ramready = 1'b0; tick();
    check("t5_no_dhit", dh_cnt, r);
    check("t5_err_clear", {31'h0, err}, 32'h0);

    // Timeout with ramready never asserted, then a successful access
    iREN = 1'b1; iaddr = 32'h48; tick();
    for (int k = 0; k < TO; k++) tick();
    check("t4_err_set", {31'h0, err}, 32'h1);
    r = ih_cnt;
    ramready = 1'b1; ramload = 32'h0BAD_F00D; tick();
    tick();
    iREN = 1'b0; ramready = 1'b0; tick();
    check("t4_later_hit", ih_cnt, r + 1);
    check("t4_err_sticky", {31'h0, err}, 32'h1);

    // Reset asserted in the middle of an instruction access
    iREN = 1'b1; iaddr = 32'h4C; tick(); tick();
    #2 nRST = 1'b0; iREN = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    r = ih_cnt;
    iREN = 1'b1; iaddr = 32'h50; ramready = 1'b1; ramload = 32'h5555_AAAA; tick();
    tick();
    iREN = 1'b0; ramready = 1'b0; tick();
    check("t6_hit_after_rst", ih_cnt, r + 1);

    // Randomized traffic with occasional aborts and timeouts
    for (int c = 0; c < 600; c++) begin
      if (!(iREN && !last_ih && $urandom_range(0, 15) != 0)) begin
        iREN  = 1'($urandom_range(0, 1));
        iaddr = $urandom;
      end
      if (!((dREN || dWEN) && !last_dh && $urandom_range(0, 15) != 0)) begin
        r      = $urandom_range(0, 3);
        dREN   = (r == 1) || (r == 3);
        dWEN   = (r == 2) || (r == 3);
        daddr  = $urandom;
        dstore = $urandom;
      end
      ramready = ($urandom_range(0, 2) == 0);
      ramload  = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory arbiter between the instruction fetch path and the data load/store path of the single-cycle datapath. It grants one requester at a time to the shared RAM port and holds the grant until the RAM signals completion. It returns a one-cycle hit pulse and the load data to the owning side. It also enforces anti-starvation alternation and a completion timeout with a sticky error flag.

## Interface
Parameters:
- TIMEOUT, 64: max cycles a granted access may wait for ramready, legal range 2..255.

Ports (word = 32 bits, cpu_types_pkg word_t):
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  instruction read request; held until ihit
- iaddr  in  32  instruction address
- ihit  out  1  one-cycle completion pulse for an instruction access
- iload  out  32  instruction data; valid while ihit=1
- dREN  in  1  data read request; held until dhit
- dWEN  in  1  data write request; held until dhit
- daddr  in  32  data address
- dstore  in  32  write data
- dhit  out  1  one-cycle completion pulse for a data access
- dload  out  32  read data; valid while dhit=1
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramready  in  1  RAM access complete this cycle
- err  out  1  sticky timeout flag

## Operation
- FSM states are IDLE, IACC and DACC. State, the last-grant bit, the timeout counter (8 bits) and err are registered. All other outputs are combinational from state and inputs.
- In IDLE, RAM outputs are 0, ihit and dhit are 0, and the counter is cleared.
- Arbitration in IDLE, evaluated on each edge:
  - If dreq = dREN|dWEN and iREN are both 1: go to DACC unless last=D, in which case go to IACC.
  - If only one request is active, grant it.
  - If neither is active, stay in IDLE.
  - last is updated to the granted side on entry to IACC or DACC.
- In IACC: ramREN=1, ramaddr=iaddr.
- In DACC with dWEN=1: ramWEN=1, ramREN=0, ramaddr=daddr, ramstore=dstore. dWEN wins if dREN and dWEN are both 1.
- In DACC with dREN only: ramREN=1, ramaddr=daddr.
- Completion:
  - In IACC with ramready=1: ihit=1, iload=ramload.
  - In DACC with ramready=1: dhit=1, dload=ramload. dload is don't-care for writes.
  - The next state after completion is always IDLE. There is no back-to-back regrant.
- Abort: if the owner drops its request while in IACC or DACC, the RAM strobes go low that same cycle, no hit is issued, and the next state is IDLE. An abort does not set err.
- Timeout:
  - The counter increments each cycle in IACC or DACC without ramready.
  - When the counter reaches TIMEOUT-1 with ramready=0: err is set, the next state is IDLE, and no hit is issued.
  - err stays at 1 until nRST. Arbitration continues normally after err is set.
- ihit and dhit are never 1 in the same cycle.
- Outputs outside their valid cycle: iload and dload are driven as ramload and are don't-care.

## Timing
- Reset (async, nRST=0):
  - state=IDLE, last=I, counter=0, err=0.
  - ihit, dhit, ramREN and ramWEN are 0. ramaddr and ramstore are 0.
- A request sampled in IDLE at edge k produces RAM strobes in cycle k+1.
- With ramready in cycle k+1+n, the hit occurs in that same cycle. Minimum request-to-hit latency is 1 cycle.
- Each access is followed by one IDLE cycle. Peak throughput is one access per 2 cycles.
- The counter is 0 in the first granted cycle. The timeout fires in the TIMEOUT-th cycle of the access.
- ramready asserted while in IDLE is ignored.
- Reset asserted mid-access returns to IDLE immediately. RAM strobes drop asynchronously.

## Test plan
- Reset, then iREN=1 with iaddr=0x40; the RAM returns 0xDEADBEEF with ramready 3 cycles after its strobe → ramREN is high for those cycles, ihit pulses once with iload=0xDEADBEEF, and the state then returns to IDLE.
- iREN and dREN are both held, and the RAM is ready after 1 cycle → grants go D, I, D, I in alternation, ihit and dhit pulse in alternation, and they are never simultaneous.
- dWEN=1, daddr=0x100, dstore=0x12345678 → ramWEN=1 and ramREN=0, ramaddr and ramstore match, and dhit=1 in the ramready cycle.
- iREN=1 and ramready is never asserted, with TIMEOUT=4 → strobes are high for 4 cycles, then err=1 and the state returns to IDLE. A later access with ramready completes and err remains 1.
- dREN is dropped during the second cycle of DACC → ramREN falls that cycle, dhit never pulses, err stays 0, and a pending iREN is granted next.
- nRST is pulsed low during IACC → all outputs reach reset values immediately, and after release an iREN completes normally.
